argon_alu_arbiter: RTL and testbench



---
 rtl/argon_pkg.sv | 32 +++
 rtl/argon_rr_arb2.sv | 28 ++
 rtl/argon_alu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_argon_alu_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/argon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : argon_pkg
// Description : Shared definitions for the ArgonALU arbiter slice. It holds the
//               opcode constants, the arbiter state encoding and the default
//               datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package argon_pkg;

    // Default datapath widths
    localparam int DEF_OPWIDTH   = 3;
    localparam int DEF_DATAWIDTH = 16;

    // ALU opcodes
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    // Arbiter state encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_EXEC = 2'd1;
    localparam arb_state_t ST_RESP = 2'd2;

endpackage : argon_pkg
`default_nettype wire

// File: rtl/argon_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : argon_rr_arb2
// Description : Two-way round-robin grant logic. A lone valid requester always
//               wins. On a tie, the requester that was not granted last wins.
//               The output is a one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module argon_rr_arb2
    import argon_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // Grant requester 0 unless requester 1 is also valid and 0 went last
    always_comb begin
        o_grant = 2'b00;
        if (i_valid[0] && (!i_valid[1] || i_last_grant)) begin
            o_grant[0] = 1'b1;
        end else if (i_valid[1]) begin
            o_grant[1] = 1'b1;
        end
    end

endmodule : argon_rr_arb2
`default_nettype wire

// File: rtl/argon_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : argon_alu_arbiter
// Description : Shares one external combinational ALU between the execute
//               stage (requester 0) and the address/branch unit (requester 1).
//               The flow is IDLE -> EXEC -> RESP, taking at least 3 cycles per
//               operation. The result and the invalid flag are returned on a
//               valid/ready channel for each requester.
//               Optional macro ARGON_ALU_ARB_STATS_EN adds per-requester grant
//               counters and a saturating invalid-op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module argon_alu_arbiter
    import argon_pkg::*;
#(
    parameter int OPWIDTH   = DEF_OPWIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req0_valid,
    output logic                 o_req0_ready,
    input  logic [OPWIDTH-1:0]   i_req0_op,
    input  logic [DATAWIDTH-1:0] i_req0_a,
    input  logic [DATAWIDTH-1:0] i_req0_b,
    output logic                 o_rsp0_valid,
    input  logic                 i_rsp0_ready,
    output logic [DATAWIDTH-1:0] o_rsp0_result,
    output logic                 o_rsp0_invalid,
    input  logic                 i_req1_valid,
    output logic                 o_req1_ready,
    input  logic [OPWIDTH-1:0]   i_req1_op,
    input  logic [DATAWIDTH-1:0] i_req1_a,
    input  logic [DATAWIDTH-1:0] i_req1_b,
    output logic                 o_rsp1_valid,
    input  logic                 i_rsp1_ready,
    output logic [DATAWIDTH-1:0] o_rsp1_result,
    output logic                 o_rsp1_invalid,
    output logic [OPWIDTH-1:0]   o_alu_op,
    output logic [DATAWIDTH-1:0] o_alu_a,
    output logic [DATAWIDTH-1:0] o_alu_b,
    input  logic [DATAWIDTH-1:0] i_alu_result,
    input  logic                 i_alu_invalid
`ifdef ARGON_ALU_ARB_STATS_EN
    ,
    output logic [15:0]          o_grant0_count,
    output logic [15:0]          o_grant1_count,
    output logic [7:0]           o_invalid_count
`endif
);

    arb_state_t            r_state;
    logic                  r_last_grant;
    logic                  r_gnt_id;
    logic [OPWIDTH-1:0]    r_alu_op;
    logic [DATAWIDTH-1:0]  r_alu_a;
    logic [DATAWIDTH-1:0]  r_alu_b;
    logic                  r_rsp0_valid;
    logic [DATAWIDTH-1:0]  r_rsp0_result;
    logic                  r_rsp0_invalid;
    logic                  r_rsp1_valid;
    logic [DATAWIDTH-1:0]  r_rsp1_result;
    logic                  r_rsp1_invalid;
    logic [1:0]            w_grant;
    logic                  w_idle;
    logic                  w_rsp_done;

    argon_rr_arb2 u_rr_arb2 (
        .i_valid      ({i_req1_valid, i_req0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Requests are only accepted from IDLE, and only by the granted requester.
    // The response handshake is taken from the requester that owns the op.
    always_comb begin
        w_idle       = (r_state == ST_IDLE);
        o_req0_ready = w_idle && w_grant[0];
        o_req1_ready = w_idle && w_grant[1];
        w_rsp_done   = r_gnt_id ? (r_rsp1_valid && i_rsp1_ready)
                                : (r_rsp0_valid && i_rsp0_ready);
    end

    // Arbitration FSM, ALU operand registers and response capture
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= 1'b1;
            r_gnt_id       <= 1'b0;
            r_alu_op       <= '0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_rsp0_valid   <= 1'b0;
            r_rsp0_result  <= '0;
            r_rsp0_invalid <= 1'b0;
            r_rsp1_valid   <= 1'b0;
            r_rsp1_result  <= '0;
            r_rsp1_invalid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant[0]) begin
                        r_alu_op <= i_req0_op;
                        r_alu_a  <= i_req0_a;
                        r_alu_b  <= i_req0_b;
                        r_gnt_id <= 1'b0;
                        r_state  <= ST_EXEC;
                    end else if (w_grant[1]) begin
                        r_alu_op <= i_req1_op;
                        r_alu_a  <= i_req1_a;
                        r_alu_b  <= i_req1_b;
                        r_gnt_id <= 1'b1;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_gnt_id) begin
                        r_rsp1_result  <= i_alu_result;
                        r_rsp1_invalid <= i_alu_invalid;
                        r_rsp1_valid   <= 1'b1;
                    end else begin
                        r_rsp0_result  <= i_alu_result;
                        r_rsp0_invalid <= i_alu_invalid;
                        r_rsp0_valid   <= 1'b1;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_done) begin
                        if (r_gnt_id) begin
                            r_rsp1_valid <= 1'b0;
                        end else begin
                            r_rsp0_valid <= 1'b0;
                        end
                        r_last_grant <= r_gnt_id;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ARGON_ALU_ARB_STATS_EN
    logic [15:0] r_grant0_count;
    logic [15:0] r_grant1_count;
    logic [7:0]  r_invalid_count;

    // Grant counters wrap; the invalid counter saturates at its maximum
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_grant0_count  <= 16'd0;
            r_grant1_count  <= 16'd0;
            r_invalid_count <= 8'd0;
        end else begin
            if (o_req0_ready) begin
                r_grant0_count <= r_grant0_count + 16'd1;
            end
            if (o_req1_ready) begin
                r_grant1_count <= r_grant1_count + 16'd1;
            end
            if ((r_state == ST_EXEC) && i_alu_invalid && (r_invalid_count != 8'hFF)) begin
                r_invalid_count <= r_invalid_count + 8'd1;
            end
        end
    end

    assign o_grant0_count  = r_grant0_count;
    assign o_grant1_count  = r_grant1_count;
    assign o_invalid_count = r_invalid_count;
`endif

    assign o_alu_op       = r_alu_op;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_rsp0_valid   = r_rsp0_valid;
    assign o_rsp0_result  = r_rsp0_result;
    assign o_rsp0_invalid = r_rsp0_invalid;
    assign o_rsp1_valid   = r_rsp1_valid;
    assign o_rsp1_result  = r_rsp1_result;
    assign o_rsp1_invalid = r_rsp1_invalid;

endmodule : argon_alu_arbiter
`default_nettype wire

// File: tb/tb_argon_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_argon_alu_arbiter
// Description : Directed self-checking bench for argon_alu_arbiter, with a
//               small behavioural ALU attached to the o_alu_* / i_alu_* ports.
//               Optional macro ARGON_ALU_ARB_STATS_EN enables the counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argon_alu_arbiter;
    import argon_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_invalid;
    logic [2:0]  req0_op;
    logic [15:0] req0_a, req0_b, rsp0_result;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_invalid;
    logic [2:0]  req1_op;
    logic [15:0] req1_a, req1_b, rsp1_result;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_invalid;
`ifdef ARGON_ALU_ARB_STATS_EN
    logic [15:0] grant0_count, grant1_count;
    logic [7:0]  invalid_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    argon_alu_arbiter #(.OPWIDTH(3), .DATAWIDTH(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req0_valid   (req0_valid),
        .o_req0_ready   (req0_ready),
        .i_req0_op      (req0_op),
        .i_req0_a       (req0_a),
        .i_req0_b       (req0_b),
        .o_rsp0_valid   (rsp0_valid),
        .i_rsp0_ready   (rsp0_ready),
        .o_rsp0_result  (rsp0_result),
        .o_rsp0_invalid (rsp0_invalid),
        .i_req1_valid   (req1_valid),
        .o_req1_ready   (req1_ready),
        .i_req1_op      (req1_op),
        .i_req1_a       (req1_a),
        .i_req1_b       (req1_b),
        .o_rsp1_valid   (rsp1_valid),
        .i_rsp1_ready   (rsp1_ready),
        .o_rsp1_result  (rsp1_result),
        .o_rsp1_invalid (rsp1_invalid),
        .o_alu_op       (alu_op),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .i_alu_result   (alu_result),
        .i_alu_invalid  (alu_invalid)
`ifdef ARGON_ALU_ARB_STATS_EN
        ,
        .o_grant0_count (grant0_count),
        .o_grant1_count (grant1_count),
        .o_invalid_count(invalid_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; opcode 7 is treated as unsupported here (result 0, flag set)
    always_comb begin
        alu_result  = 16'h0000;
        alu_invalid = 1'b0;
        case (alu_op)
            OP_ADD: alu_result = alu_a + alu_b;
            OP_SUB: alu_result = alu_a - alu_b;
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_XOR: alu_result = alu_a ^ alu_b;
            OP_SLL: alu_result = alu_a << alu_b[3:0];
            OP_SRL: alu_result = alu_a >> alu_b[3:0];
            default: begin
                alu_result  = 16'h0000;
                alu_invalid = 1'b1;
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One complete operation on a single requester, no checks on the data
    task automatic run_op(input bit id, input logic [2:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = 16'h0001; req1_b = 16'h0001;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = 16'h0001; req0_b = 16'h0001;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; rsp1_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_result", rsp0_result, 0);
        check("rst_alu_op_a_b", {alu_op, alu_a, alu_b} == 0, 1);
        check("rst_ready", {req1_ready, req0_ready}, 0);

        // Single request: ADD 3+4 on requester 0
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h0003; req0_b = 16'h0004;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        tick();                                   // accept (cycle N)
        req0_valid = 1'b0;
        check("single_alu_a", alu_a, 16'h0003);
        check("single_exec_noresp", rsp0_valid, 0);
        check("single_exec_ready0", req0_ready, 0);
        tick();                                   // cycle N+2
        check("single_rsp0_valid", rsp0_valid, 1);
        check("single_rsp0_result", rsp0_result, 16'h0007);
        check("single_rsp0_invalid", rsp0_invalid, 0);
        check("single_rsp1_valid", rsp1_valid, 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("single_rsp0_cleared", rsp0_valid, 0);

        // Tie after reset: requester 0 first, then requester 1
        do_reset();
        req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 16'h0010; req0_b = 16'h0001;
        req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 16'h00FF; req1_b = 16'h0F0F;
        #1;
        check("tie_ready0", req0_ready, 1);
        check("tie_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        check("tie_rsp0_result", rsp0_result, 16'h000F);
        check("tie_rsp0_valid", rsp0_valid, 1);
        check("tie_resp_ready1", req1_ready, 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("tie_idle_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("tie_rsp1_valid", rsp1_valid, 1);
        check("tie_rsp1_result", rsp1_result, 16'h0FF0);

        // Backpressure on requester 1 while requester 0 waits
        req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 16'h0010; req0_b = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp1_valid", rsp1_valid, 1);
            check("bp_rsp1_result", rsp1_result, 16'h0FF0);
            check("bp_no_accept", req0_ready, 0);
        end
        rsp1_ready = 1'b1;
        req1_valid = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        check("bp_rsp1_cleared", rsp1_valid, 0);
        check("alt_ready0", req0_ready, 1);
        check("alt_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("alt_rsp0_result", rsp0_result, 16'h000F);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // Invalid opcode relayed from the ALU
        req0_valid = 1'b1; req0_op = OP_SLT; req0_a = 16'h0005; req0_b = 16'h0009;
        tick();
        req0_valid = 1'b0;
        check("inv_alu_op", alu_op, 7);
        tick();
        check("inv_rsp0_invalid", rsp0_invalid, 1);
        check("inv_rsp0_result", rsp0_result, 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

        // Reset while an operation for requester 1 is in EXEC
        req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 16'h0001; req1_b = 16'h0002;
        tick();
        req1_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_rsp1_valid", rsp1_valid, 0);
        check("midrst_rsp0_valid", rsp0_valid, 0);
        check("midrst_alu_a", alu_a, 0);
        req0_valid = 1'b1; req0_op = OP_AND; req0_a = 16'h00F0; req0_b = 16'h0FF0;
        req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 16'h0001; req1_b = 16'h0002;
        #1;
        check("midrst_tie_ready0", req0_ready, 1);
        check("midrst_tie_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("midrst_rsp0_result", rsp0_result, 16'h00F0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;

`ifdef ARGON_ALU_ARB_STATS_EN
        do_reset();
        check("stats_rst_g0", grant0_count, 0);
        check("stats_rst_inv", invalid_count, 0);
        run_op(1'b0, OP_ADD);
        run_op(1'b1, OP_ADD);
        run_op(1'b0, OP_ADD);
        run_op(1'b1, OP_SLT);
        run_op(1'b0, OP_ADD);
        check("stats_g0", grant0_count, 3);
        check("stats_g1", grant1_count, 2);
        check("stats_inv_one", invalid_count, 1);
        for (int i = 0; i < 300; i++) begin
            run_op(1'b0, OP_SLT);
        end
        check("stats_inv_sat", invalid_count, 8'hFF);
        check("stats_g0_after", grant0_count, 303);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_argon_alu_arbiter
`default_nettype wire
